// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters, sync pulses, visible-area flag,
// frame counter and one-cycle line/frame start strobes, all registered.
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter int unsigned SYNC_POL = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pix_en,
   output logic       hsync,
   output logic       vsync,
   output logic       display_on,
   output logic [9:0] hpos,
   output logic [9:0] vpos,
   output logic [7:0] frame_cnt,
   output logic       line_start,
   output logic       frame_start
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
   localparam logic [10:0] H_VIS  = 11'(H_ACTIVE);
   localparam logic [10:0] V_VIS  = 11'(V_ACTIVE);
   localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic        SYNC_ON = (SYNC_POL != 0);

   logic       h_wrap;
   logic       v_wrap;
   logic [9:0] h_nxt;
   logic [9:0] v_nxt;
   logic [7:0] f_nxt;
   logic       hs_nxt;
   logic       vs_nxt;
   logic       de_nxt;

   // Decodes use the post-advance counters so syncs/display_on line up with hpos/vpos.
   always_comb begin
      h_wrap = (hpos == H_LAST);
      v_wrap = (vpos == V_LAST);
      h_nxt  = h_wrap ? '0 : hpos + 10'd1;
      v_nxt  = vpos;
      f_nxt  = frame_cnt;
      if (h_wrap) begin
         v_nxt = v_wrap ? '0 : vpos + 10'd1;
         if (v_wrap) begin
            f_nxt = frame_cnt + 8'd1;
         end
      end
      hs_nxt = (({1'b0, h_nxt} >= HS_BEG) && ({1'b0, h_nxt} <= HS_END)) ? SYNC_ON : ~SYNC_ON;
      vs_nxt = (({1'b0, v_nxt} >= VS_BEG) && ({1'b0, v_nxt} <= VS_END)) ? SYNC_ON : ~SYNC_ON;
      de_nxt = ({1'b0, h_nxt} < H_VIS) && ({1'b0, v_nxt} < V_VIS);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hpos        <= '0;
         vpos        <= '0;
         frame_cnt   <= '0;
         hsync       <= ~SYNC_ON;
         vsync       <= ~SYNC_ON;
         display_on  <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else if (pix_en) begin
         hpos        <= h_nxt;
         vpos        <= v_nxt;
         frame_cnt   <= f_nxt;
         hsync       <= hs_nxt;
         vsync       <= vs_nxt;
         display_on  <= de_nxt;
         line_start  <= h_wrap;
         frame_start <= h_wrap && v_wrap;
      end else begin
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end
   end

endmodule
